apx_fp_mul_cfg: RTL and testbench

//  Approximate IEEE-754 single-precision multiplier; successor to the fixed-truncation

---
 rtl/apx_fp_mul_cfg.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_apx_fp_mul_cfg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apx_fp_mul_cfg.sv
// apx_fp_mul_cfg: approximate IEEE-754 single-precision multiplier.
// Per-operation truncation depth (in_nab, clamped to NAB_MAX) drops low fraction
// bits of both operands and of the result. Fixed 5-edge latency from the accepting
// edge to out_valid, valid/ready on both sides, flags {invalid, overflow, underflow}.
// Build option: define APX_FTZ_EN to treat subnormal inputs as zero and flush
// results below the normal range to signed zero (gradual underflow compiled out).
module apx_fp_mul_cfg #(
   parameter int unsigned NAB_MAX = 16,
   parameter int unsigned NAB_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [NAB_W-1:0] in_nab,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      out_z,
   output logic [2:0]       out_flags,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned EW = 10;   // signed unbiased exponent width
   localparam int unsigned MW = 24;   // mantissa incl. hidden bit
   localparam int unsigned PW = 48;   // full product width
   localparam int unsigned FW = 23;   // stored fraction width
   localparam int unsigned LW = 6;    // leading-zero count width

   localparam logic signed [EW-1:0] C_EMIN = -10'sd126;
   localparam logic signed [EW-1:0] C_EMAX = 10'sd127;
   localparam logic signed [EW-1:0] C_BIAS = 10'sd127;
   localparam logic signed [EW-1:0] C_ONE  = 10'sd1;
   localparam logic [31:0]          C_QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_MUL,
      ST_NORM,
      ST_RND,
      ST_DONE
   } state_t;

   // unbiased exponent; subnormal/zero fields map to the minimum normal exponent
   function automatic logic signed [EW-1:0] f_uexp(input logic [7:0] e);
      return (e == 8'd0) ? C_EMIN : $signed(EW'(e)) - C_BIAS;
   endfunction

   // leading-zero count of the product (48 when the product is zero)
   function automatic logic [LW-1:0] f_lzc(input logic [PW-1:0] v);
      logic [LW-1:0] c;
      c = LW'(PW);
      for (int i = 0; i < int'(PW); i++) begin
         if (v[i]) c = LW'(int'(PW) - 1 - i);
      end
      return c;
   endfunction

   state_t r_state, w_state_nxt;

   logic                 r_in_ready, r_out_valid;
   logic [31:0]          r_out_z;
   logic [2:0]           r_out_flags;

   logic [31:0]          r_a, r_b;
   logic [NAB_W-1:0]     r_n;

   logic [MW-1:0]        r_ma, r_mb;
   logic signed [EW-1:0] r_ea, r_eb;
   logic                 r_zs, r_spec, r_spec_inv;
   logic [31:0]          r_spec_z;

   logic [PW-1:0]        r_p;
   logic signed [EW-1:0] r_ze;

   logic [PW-1:0]        r_m;
   logic signed [EW-1:0] r_ze_n;
   logic                 r_stk, r_pzero;

   logic [MW-1:0]        r_q;
   logic signed [EW-1:0] r_ze_r;
   logic                 r_inx;

   logic                 w_accept;
   logic [NAB_W-1:0]     w_n_clamp;
   logic [FW-1:0]        w_fmask;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_z     = r_out_z;
   assign out_flags = r_out_flags;

   assign w_accept  = (r_state == ST_IDLE) && in_valid && r_in_ready;
   assign w_n_clamp = (32'(in_nab) > NAB_MAX) ? NAB_W'(NAB_MAX) : in_nab;
   assign w_fmask   = (FW'(1) << r_n) - FW'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: one pass through the pipeline stages, DONE waits for the consumer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_UNPACK;
         ST_UNPACK: w_state_nxt = ST_MUL;
         ST_MUL:    w_state_nxt = ST_NORM;
         ST_NORM:   w_state_nxt = ST_RND;
         ST_RND:    w_state_nxt = ST_DONE;
         ST_DONE:   if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture with clamped truncation depth
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= in_a;
         r_b <= in_b;
         r_n <= w_n_clamp;
      end
   end

   // ---------------- UNPACK ----------------
   logic [7:0]  w_xa, w_xb;
   logic [FW-1:0] w_fa, w_fb;
   logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_zs;
   logic        w_spec, w_spec_inv;
   logic [31:0] w_spec_z;

   assign w_xa    = r_a[30:23];
   assign w_xb    = r_b[30:23];
   assign w_fa    = r_a[22:0];
   assign w_fb    = r_b[22:0];
   assign w_zs    = r_a[31] ^ r_b[31];
   assign w_nan_a = (&w_xa) && (|w_fa);
   assign w_nan_b = (&w_xb) && (|w_fb);
   assign w_inf_a = (&w_xa) && !(|w_fa);
   assign w_inf_b = (&w_xb) && !(|w_fb);
`ifdef APX_FTZ_EN
   assign w_zero_a = !(|w_xa);
   assign w_zero_b = !(|w_xb);
`else
   assign w_zero_a = !(|w_xa) && !(|w_fa);
   assign w_zero_b = !(|w_xb) && !(|w_fb);
`endif

   // Special-operand classification, priority NaN > inf*0 > inf > zero
   always_comb begin
      w_spec     = 1'b1;
      w_spec_inv = 1'b0;
      w_spec_z   = C_QNAN;
      if (w_nan_a || w_nan_b) begin
         w_spec_z = C_QNAN;
      end else if ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
         w_spec_z   = C_QNAN;
         w_spec_inv = 1'b1;
      end else if (w_inf_a || w_inf_b) begin
         w_spec_z = {w_zs, 8'hFF, 23'd0};
      end else if (w_zero_a || w_zero_b) begin
         w_spec_z = {w_zs, 31'd0};
      end else begin
         w_spec = 1'b0;
      end
   end

   // Unpack stage: truncated mantissas, unbiased exponents, special bypass
   always_ff @(posedge clk) begin
      if (r_state == ST_UNPACK) begin
         r_ma       <= {(|w_xa), w_fa & ~w_fmask};
         r_mb       <= {(|w_xb), w_fb & ~w_fmask};
         r_ea       <= f_uexp(w_xa);
         r_eb       <= f_uexp(w_xb);
         r_zs       <= w_zs;
         r_spec     <= w_spec;
         r_spec_z   <= w_spec_z;
         r_spec_inv <= w_spec_inv;
      end
   end

   // Multiply stage
   always_ff @(posedge clk) begin
      if (r_state == ST_MUL) begin
         r_p  <= PW'(r_ma) * PW'(r_mb);
         r_ze <= r_ea + r_eb;
      end
   end

   // ---------------- NORM ----------------
   logic [LW-1:0]        w_lzc;
   logic [PW-1:0]        w_m_sh, w_m_n;
   logic signed [EW-1:0] w_ze_n, w_ze_f;
   logic                 w_stk;

   assign w_lzc  = f_lzc(r_p);
   assign w_m_sh = r_p << w_lzc;
   assign w_ze_n = r_ze + C_ONE - $signed(EW'(w_lzc));

`ifdef APX_FTZ_EN
   assign w_m_n  = w_m_sh;
   assign w_ze_f = w_ze_n;
   assign w_stk  = 1'b0;
`else
   logic signed [EW-1:0] w_rs_full;
   logic [4:0]           w_rs;

   assign w_rs_full = C_EMIN - w_ze_n;

   // Denormalise below the normal range; bits shifted out collapse into sticky
   always_comb begin
      w_rs   = 5'd0;
      w_m_n  = w_m_sh;
      w_ze_f = w_ze_n;
      w_stk  = 1'b0;
      if (w_ze_n < C_EMIN) begin
         w_rs   = (w_rs_full > 10'sd26) ? 5'd26 : 5'(w_rs_full);
         w_m_n  = w_m_sh >> w_rs;
         w_stk  = |(w_m_sh & ((PW'(1) << w_rs) - PW'(1)));
         w_ze_f = C_EMIN;
      end
   end
`endif

   // Normalise stage
   always_ff @(posedge clk) begin
      if (r_state == ST_NORM) begin
         r_m     <= w_m_n;
         r_ze_n  <= w_ze_f;
         r_stk   <= w_stk;
         r_pzero <= !(|r_p);
      end
   end

   // ---------------- RND ----------------
   logic [MW-1:0] w_keep;
   logic          w_g, w_s, w_rup;
   logic [MW:0]   w_sum;

   assign w_keep = r_m[PW-1:PW-MW];
   assign w_g    = r_m[PW-MW-1];
   assign w_s    = (|r_m[PW-MW-2:0]) | r_stk;
   assign w_rup  = w_g & (w_s | w_keep[0]);
   assign w_sum  = {1'b0, w_keep} + (MW+1)'(w_rup);

   // Round-to-nearest-even; a carry out renormalises to 1.0 with exponent + 1
   always_ff @(posedge clk) begin
      if (r_state == ST_RND) begin
         r_inx <= w_g | w_s;
         if (w_sum[MW]) begin
            r_q    <= {1'b1, {(MW-1){1'b0}}};
            r_ze_r <= r_ze_n + C_ONE;
         end else begin
            r_q    <= w_sum[MW-1:0];
            r_ze_r <= r_ze_n;
         end
      end
   end

   // ---------------- PACK ----------------
   logic [FW-1:0] w_frac;
   logic          w_cut;
   logic [31:0]   w_pk_z;
   logic [2:0]    w_pk_f;

   assign w_frac = r_q[FW-1:0] & ~w_fmask;
   assign w_cut  = |(r_q[FW-1:0] & w_fmask);

   // Result packing: specials, overflow, normal and subnormal encodings
   always_comb begin
      w_pk_z = {r_zs, 31'd0};
      w_pk_f = 3'b000;
      if (r_spec) begin
         w_pk_z = r_spec_z;
         w_pk_f = {r_spec_inv, 2'b00};
      end else if (r_pzero) begin
         w_pk_z = {r_zs, 31'd0};
      end else if (r_ze_r > C_EMAX) begin
         w_pk_z = {r_zs, 8'hFF, 23'd0};
         w_pk_f = 3'b010;
`ifdef APX_FTZ_EN
      end else if (r_ze_r < C_EMIN) begin
         w_pk_z = {r_zs, 31'd0};
         w_pk_f = 3'b001;
`endif
      end else if (r_q[MW-1]) begin
         w_pk_z = {r_zs, 8'(r_ze_r + C_BIAS), w_frac};
      end else begin
         w_pk_z = {r_zs, 8'h00, w_frac};
         w_pk_f = {2'b00, r_inx | w_cut};
      end
   end

   // Handshake and output registers; result held until the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_z     <= 32'd0;
         r_out_flags <= 3'b000;
      end else begin
         r_in_ready <= (w_state_nxt == ST_IDLE);
         if (r_state == ST_DONE) begin
            if (!r_out_valid) begin
               r_out_valid <= 1'b1;
               r_out_z     <= w_pk_z;
               r_out_flags <= w_pk_f;
            end else if (out_ready) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_apx_fp_mul_cfg.sv
// Bench for apx_fp_mul_cfg: directed vector table, handshake/reset sequences and
// randomized operations against an exact-arithmetic reference model.
module tb_apx_fp_mul_cfg;

   localparam int NAB_MAX = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_nab;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_z;
   logic [2:0]  out_flags;
   logic        out_valid;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   apx_fp_mul_cfg dut (
      .clk       (clk),
      .rst       (rst),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_nab    (in_nab),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_z     (out_z),
      .out_flags (out_flags),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  nab;
      logic [31:0] z;
      logic [2:0]  f;
   } vec_t;

`ifdef APX_FTZ_EN
   localparam logic [31:0] T_SUB_Z  = 32'h0000_0000;
   localparam logic [31:0] T_HALF_Z = 32'h0000_0000;
   localparam logic [2:0]  T_HALF_F = 3'b001;
   localparam logic [31:0] T_TIE_Z  = 32'h0000_0000;
   localparam logic [2:0]  T_TIE_F  = 3'b001;
`else
   localparam logic [31:0] T_SUB_Z  = 32'h0080_0000;
   localparam logic [31:0] T_HALF_Z = 32'h0040_0000;
   localparam logic [2:0]  T_HALF_F = 3'b000;
   localparam logic [31:0] T_TIE_Z  = 32'h0040_0000;
   localparam logic [2:0]  T_TIE_F  = 3'b001;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Exact reference: integer product, round once at the target ulp, then truncate
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] nab,
                                   output logic [31:0] z, output logic [2:0] f);
      int n, ea, eb, e, er, k, sh;
      longint unsigned lowm, ma, mb, p, q;
      logic [7:0] xa, xb;
      logic [22:0] fa, fb;
      bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, g, st, cut;
      n    = (int'(nab) > NAB_MAX) ? NAB_MAX : int'(nab);
      lowm = (64'd1 << n) - 64'd1;
      xa = a[30:23]; xb = b[30:23]; fa = a[22:0]; fb = b[22:0];
      s  = a[31] ^ b[31];
      nan_a = (xa == 8'hFF) && (fa != 0);
      nan_b = (xb == 8'hFF) && (fb != 0);
      inf_a = (xa == 8'hFF) && (fa == 0);
      inf_b = (xb == 8'hFF) && (fb == 0);
`ifdef APX_FTZ_EN
      zero_a = (xa == 0);
      zero_b = (xb == 0);
`else
      zero_a = (xa == 0) && (fa == 0);
      zero_b = (xb == 0) && (fb == 0);
`endif
      f = 3'b000;
      if (nan_a || nan_b) begin z = 32'h7FC00000; return; end
      if ((inf_a && zero_b) || (zero_a && inf_b)) begin z = 32'h7FC00000; f = 3'b100; return; end
      if (inf_a || inf_b) begin z = {s, 8'hFF, 23'd0}; return; end
      if (zero_a || zero_b) begin z = {s, 31'd0}; return; end
      ma = longint'(fa) & ~lowm;
      mb = longint'(fb) & ~lowm;
      if (xa != 0) ma += 64'd1 << 23;
      if (xb != 0) mb += 64'd1 << 23;
      ea = (xa != 0) ? int'(xa) - 127 : -126;
      eb = (xb != 0) ? int'(xb) - 127 : -126;
      p  = ma * mb;
      if (p == 0) begin z = {s, 31'd0}; return; end
      k = 0;
      for (int i = 0; i < 48; i++) if (p[i]) k = i;
      e  = ea + eb - 46;
      er = k + e;
`ifndef APX_FTZ_EN
      if (er < -126) er = -126;
`endif
      sh = (er - 23) - e;
      if (sh <= 0) begin
         q = p << (-sh); g = 0; st = 0;
      end else if (sh > 49) begin
         q = 0; g = 0; st = 1;
      end else begin
         q  = p >> sh;
         g  = ((p >> (sh - 1)) & 64'd1) != 0;
         st = (p & ((64'd1 << (sh - 1)) - 64'd1)) != 0;
      end
      if (g && (st || q[0])) q++;
      if (q == (64'd1 << 24)) begin q = 64'd1 << 23; er++; end
      if (er > 127) begin z = {s, 8'hFF, 23'd0}; f = 3'b010; return; end
`ifdef APX_FTZ_EN
      if (er < -126) begin z = {s, 31'd0}; f = 3'b001; return; end
`endif
      cut = (q & lowm) != 0;
      q   = q & ~lowm;
      if (q >= (64'd1 << 23)) z = {s, 8'(er + 127), 23'(q)};
      else begin
         z = {s, 8'd0, 23'(q)};
         f = {2'b00, g | st | cut};
      end
   endfunction

   task automatic wait_ready(input string nm);
      int cnt = 0;
      while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
      if (!in_ready) chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
   endtask

   // One full transaction: accept, latency, result, optional back-pressure, handshake
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] nab,
                         input int hold, input logic [31:0] ez, input logic [2:0] ef,
                         input string nm);
      int cnt;
      wait_ready(nm);
      in_a = a; in_b = b; in_nab = nab; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_nab = 5'($urandom);
      cnt = 0;
      while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
      chk({nm, "_lat"}, 32'(cnt), 32'd5);
      chk({nm, "_z"}, out_z, ez);
      chk({nm, "_f"}, 32'(out_flags), 32'(ef));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk($sformatf("%s_hold%0d_z", nm, h), out_z, ez);
         chk($sformatf("%s_hold%0d_f", nm, h), 32'(out_flags), 32'(ef));
         chk($sformatf("%s_hold%0d_v", nm, h), 32'(out_valid), 32'd1);
         chk($sformatf("%s_hold%0d_rdy", nm, h), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_v_clr"}, 32'(out_valid), 32'd0);
      chk({nm, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   function automatic logic [31:0] rnd_fp();
      int c;
      logic [7:0] e;
      c = $urandom_range(0, 9);
      case (c)
         0:       return $urandom;
         1:       e = 8'd0;
         2:       e = 8'($urandom_range(1, 30));
         3:       e = 8'($urandom_range(220, 254));
         default: e = 8'($urandom_range(90, 165));
      endcase
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      bit seen;
      logic [31:0] ra, rb, ez;
      logic [4:0]  rn;
      logic [2:0]  ef;

      tbl[0]  = '{32'h3FC00000, 32'h40000000, 5'd0,  32'h40400000, 3'b000};
      tbl[1]  = '{32'h3F8CCCCD, 32'h3F800000, 5'd16, 32'h3F8C0000, 3'b000};
      tbl[2]  = '{32'h3F8CCCCD, 32'h3F800000, 5'd31, 32'h3F8C0000, 3'b000};
      tbl[3]  = '{32'h7FC00001, 32'h3F800000, 5'd0,  32'h7FC00000, 3'b000};
      tbl[4]  = '{32'h7F800000, 32'h00000000, 5'd0,  32'h7FC00000, 3'b100};
      tbl[5]  = '{32'h7F000000, 32'h7F000000, 5'd0,  32'h7F800000, 3'b010};
      tbl[6]  = '{32'hFF000000, 32'h7F000000, 5'd0,  32'hFF800000, 3'b010};
      tbl[7]  = '{32'h00000001, 32'h4B000000, 5'd0,  T_SUB_Z,      3'b000};
      tbl[8]  = '{32'h3F8CCCCD, 32'h3F800000, 5'd0,  32'h3F8CCCCD, 3'b000};
      tbl[9]  = '{32'h00800000, 32'h3F000000, 5'd0,  T_HALF_Z,     T_HALF_F};
      tbl[10] = '{32'h00800001, 32'h3F000000, 5'd0,  T_TIE_Z,      T_TIE_F};
      tbl[11] = '{32'h3F800001, 32'h3F800001, 5'd0,  32'h3F800002, 3'b000};
      tbl[12] = '{32'h7F7FFFFF, 32'h3F800001, 5'd0,  32'h7F800000, 3'b010};
      tbl[13] = '{32'h3F800001, 32'h3F800001, 5'd2,  32'h3F800000, 3'b000};
      tbl[14] = '{32'hFF800000, 32'h3F800000, 5'd0,  32'hFF800000, 3'b000};
      tbl[15] = '{32'h80000000, 32'h3F800000, 5'd0,  32'h80000000, 3'b000};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 32'd0; in_b = 32'd0; in_nab = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_z", out_z, 32'd0);
      chk("reset_out_flags", 32'(out_flags), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("first_clean_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 16; i++)
         run_op(tbl[i].a, tbl[i].b, tbl[i].nab, 0, tbl[i].z, tbl[i].f, $sformatf("vec%0d", i));

      // Consumer stalls three cycles in DONE
      run_op(tbl[0].a, tbl[0].b, tbl[0].nab, 3, tbl[0].z, tbl[0].f, "stall3");

      // Reset pulsed while the operation sits in MUL
      wait_ready("rst_mul");
      in_a = tbl[0].a; in_b = tbl[0].b; in_nab = 5'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mul_in_ready_low", 32'(in_ready), 32'd0);
      chk("rst_mul_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("rst_mul_in_ready_up", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("rst_mul_no_result", 32'(seen), 32'd0);
      run_op(tbl[8].a, tbl[8].b, tbl[8].nab, 0, tbl[8].z, tbl[8].f, "after_rst");

      // Randomized operations against the reference model
      for (int r = 0; r < 300; r++) begin
         ra = rnd_fp();
         rb = rnd_fp();
         rn = 5'($urandom_range(0, 31));
         ref_mul(ra, rb, rn, ez, ef);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(ra, rb, rn, $urandom_range(0, 2), ez, ef,
                $sformatf("rnd%0d_%h_%h_n%0d", r, ra, rb, rn));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
